// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator.
// Each channel runs an ACC_W-bit phase accumulator; the carry out of the
// accumulator becomes a registered one-cycle enable pulse. All channels are
// gated by a filtered PLL lock, and loss of lock while ready is latched.
// Optional feature macro: CLK_EN_LOCK_SYNC_EN puts pll_lock through a 2-flop
// synchronizer before the lock filter (default build: lock used directly).

module clk_en_gen #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned LOCK_FILT = 16
) (
  input  logic                                               clk,
  input  logic                                               resetn,
  input  logic                                               pll_lock,
  input  logic                                               cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                                   cfg_inc,
  input  logic [CHANNELS-1:0]                                run,
  input  logic                                               clr_lost,
  output logic [CHANNELS-1:0]                                ce,
  output logic                                               ready,
  output logic                                               lost_lock
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = $clog2(LOCK_FILT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILT);

  // ---------------------------------------------------------------------------
  // Reset release: assert asynchronously, release on a clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Two-stage reset release synchronizer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Lock sample
  // ---------------------------------------------------------------------------
  logic lock_s;

`ifdef CLK_EN_LOCK_SYNC_EN
  logic [1:0] lock_sync_q;

  // Bring the raw PLL lock into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock};
    end
  end

  assign lock_s = lock_sync_q[1];
`else
  // pll_lock is already synchronous to clk in this build.
  assign lock_s = pll_lock;
`endif

  // ---------------------------------------------------------------------------
  // Lock filter, ready and sticky lost-lock flag
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             lost_q, lost_d;
  logic             acc_en;

  // Count consecutive lock-high samples; ready once the count saturates.
  always_comb begin
    cnt_d   = '0;
    ready_d = 1'b0;
    if (lock_s) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      ready_d = (cnt_d == CNT_MAX);
    end
  end

  // Latch a lock drop seen while ready; a new drop beats a clear request.
  always_comb begin
    lost_d = lost_q;
    if (clr_lost) begin
      lost_d = 1'b0;
    end
    if (ready_q && !lock_s) begin
      lost_d = 1'b1;
    end
  end

  // Lock filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Accumulate only while ready and still locked, so the edge that drops
  // ready also zeroes every enable and accumulator.
  assign acc_en = ready_q & lock_s;

  assign ready     = ready_q;
  assign lost_lock = lost_q;

  // ---------------------------------------------------------------------------
  // Per-channel phase accumulators
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic             ce_q, ce_d;
    logic             ch_en;

    assign ch_en = acc_en & run[g];
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};

    // Increment register: only an exact index match loads, so any index
    // beyond the last channel falls through untouched.
    always_comb begin
      inc_d = inc_q;
      if (cfg_we && (cfg_ch == CH_W'(g))) begin
        inc_d = cfg_inc;
      end
    end

    // Carry out of the accumulator is the enable; disabled channels restart at phase 0.
    always_comb begin
      acc_d = '0;
      ce_d  = 1'b0;
      if (ch_en) begin
        acc_d = sum[ACC_W-1:0];
        ce_d  = sum[ACC_W];
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inc_q <= '0;
        acc_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        inc_q <= inc_d;
        acc_q <= acc_d;
        ce_q  <= ce_d;
      end
    end

    assign ce[g] = ce_q;
  end

endmodule
